// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions used by the branch predictor:
// the 2-bit direction counter and the BTB entry layout.
package lc3b_types;

    typedef logic [1:0] lc3b_bp_ctr_t;

    localparam lc3b_bp_ctr_t BP_STRONG_NT = 2'b00;
    localparam lc3b_bp_ctr_t BP_WEAK_NT   = 2'b01;
    localparam lc3b_bp_ctr_t BP_WEAK_T    = 2'b10;
    localparam lc3b_bp_ctr_t BP_STRONG_T  = 2'b11;

    // Entry layout for the default 16-bit PC with a 16-entry table.
    localparam int BP_PC_W  = 16;
    localparam int BP_IDX_W = 4;
    localparam int BP_TAG_W = BP_PC_W - BP_IDX_W - 1;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_PC_W-1:0]  target;
        logic                uncond;
        lc3b_bp_ctr_t        ctr;
    } lc3b_btb_entry_t;

endpackage

// File: rtl/lc3b_branch_predictor_sat_counter2.sv
// Next-state logic for a 2-bit saturating direction counter.
module sat_counter2
    import lc3b_types::*;
(
    input  lc3b_bp_ctr_t ctr_i,
    input  logic         taken_i,
    output lc3b_bp_ctr_t ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != BP_STRONG_T) begin
                ctr_o = ctr_i + 2'b01;
            end
        end else begin
            if (ctr_i != BP_STRONG_NT) begin
                ctr_o = ctr_i - 2'b01;
            end
        end
    end

endmodule

// File: rtl/lc3b_branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters for the LC-3b fetch stage,
// trained from branch resolution, plus saturating hit/mispredict counters.
module lc3b_branch_predictor
    import lc3b_types::*;
#(
    parameter int ENTRIES    = 16,
    parameter int PC_WIDTH   = 16,
    parameter int PERF_WIDTH = 16,
    parameter int MODE       = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [PC_WIDTH-1:0]   fetch_pc,
    output logic                  pred_taken,
    output logic [PC_WIDTH-1:0]   pred_target,
    input  logic                  upd_valid,
    input  logic [PC_WIDTH-1:0]   upd_pc,
    input  logic                  upd_taken,
    input  logic                  upd_uncond,
    input  logic [PC_WIDTH-1:0]   upd_target,
    input  logic                  upd_mispredict,
    input  logic                  invalidate,
    output logic [PERF_WIDTH-1:0] hit_count,
    output logic [PERF_WIDTH-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_WIDTH - IDX_W - 1;
    localparam logic BP_EN = (MODE != 0);
    localparam logic [PERF_WIDTH-1:0] PERF_MAX = '1;

    logic [ENTRIES-1:0]    valid_q, valid_d;
    logic [ENTRIES-1:0]    uncond_q, uncond_d;
    lc3b_bp_ctr_t          ctr_q [ENTRIES];
    lc3b_bp_ctr_t          ctr_d [ENTRIES];
    logic [TAG_W-1:0]      tag_q [ENTRIES];
    logic [PC_WIDTH-1:0]   target_q [ENTRIES];
    logic [PERF_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
    logic [PERF_WIDTH-1:0] misp_cnt_q, misp_cnt_d;

    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             lookup_hit;
    logic             upd_hit;
    logic             upd_en;
    logic             row_wr;
    logic             alloc;
    logic             tgt_wr;
    lc3b_bp_ctr_t     ctr_trained;
    lc3b_bp_ctr_t     ctr_wr;
    logic             unused_upd_pc0;

    assign f_idx = fetch_pc[IDX_W:1];
    assign f_tag = fetch_pc[PC_WIDTH-1:IDX_W+1];
    assign u_idx = upd_pc[IDX_W:1];
    assign u_tag = upd_pc[PC_WIDTH-1:IDX_W+1];
    assign unused_upd_pc0 = upd_pc[0];

    // Lookup reads only registered state, so a same-cycle update is not bypassed.
    assign lookup_hit  = BP_EN && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign pred_taken  = lookup_hit && (uncond_q[f_idx] || ctr_q[f_idx][1]);
    assign pred_target = pred_taken ? target_q[f_idx] : (fetch_pc + PC_WIDTH'(2));

    assign upd_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    sat_counter2 u_sat_counter2 (
        .ctr_i   (ctr_q[u_idx]),
        .taken_i (upd_taken),
        .ctr_o   (ctr_trained)
    );

    always_comb begin
        upd_en = BP_EN && upd_valid && !invalidate;
        row_wr = 1'b0;
        alloc  = 1'b0;
        tgt_wr = 1'b0;
        ctr_wr = ctr_trained;
        if (upd_en) begin
            if (upd_hit) begin
                row_wr = 1'b1;
                if (upd_uncond) begin
                    ctr_wr = BP_STRONG_T;
                    tgt_wr = 1'b1;
                end else begin
                    tgt_wr = upd_taken;
                end
            end else if (upd_taken || upd_uncond) begin
                row_wr = 1'b1;
                alloc  = 1'b1;
                tgt_wr = 1'b1;
                ctr_wr = upd_uncond ? BP_STRONG_T : BP_WEAK_T;
            end
        end
    end

    always_comb begin
        valid_d  = valid_q;
        uncond_d = uncond_q;
        ctr_d    = ctr_q;
        if (invalidate) begin
            valid_d = '0;
        end else if (row_wr) begin
            valid_d[u_idx] = 1'b1;
            ctr_d[u_idx]   = ctr_wr;
            if (alloc) begin
                uncond_d[u_idx] = upd_uncond;
            end
        end
    end

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        misp_cnt_d = misp_cnt_q;
        if (lookup_hit && (hit_cnt_q != PERF_MAX)) begin
            hit_cnt_d = hit_cnt_q + PERF_WIDTH'(1);
        end
        if (upd_valid && upd_mispredict && (misp_cnt_q != PERF_MAX)) begin
            misp_cnt_d = misp_cnt_q + PERF_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q    <= '0;
            uncond_q   <= '0;
            hit_cnt_q  <= '0;
            misp_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= BP_WEAK_NT;
            end
        end else begin
            valid_q    <= valid_d;
            uncond_q   <= uncond_d;
            hit_cnt_q  <= hit_cnt_d;
            misp_cnt_q <= misp_cnt_d;
            ctr_q      <= ctr_d;
        end
    end

    // Tag and target are only meaningful under a valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        if (alloc) begin
            tag_q[u_idx] <= u_tag;
        end
        if (tgt_wr) begin
            target_q[u_idx] <= upd_target;
        end
    end

    assign hit_count        = hit_cnt_q;
    assign mispredict_count = misp_cnt_q;

endmodule

// File: tb/tb_lc3b_branch_predictor.sv
// Directed scoreboard bench for lc3b_branch_predictor: a default instance,
// a 4-bit perf-counter instance and a MODE=0 instance share one stimulus.
module tb_lc3b_branch_predictor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] fetch_pc;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic        upd_uncond;
    logic [15:0] upd_target;
    logic        upd_mispredict;
    logic        invalidate;

    logic        pred_taken;
    logic [15:0] pred_target;
    logic [15:0] hit_count;
    logic [15:0] mispredict_count;

    logic        p4_pred_taken;
    logic [15:0] p4_pred_target;
    logic [3:0]  p4_hit_count;
    logic [3:0]  p4_mispredict_count;

    logic        m0_pred_taken;
    logic [15:0] m0_pred_target;
    logic [15:0] m0_hit_count;
    logic [15:0] m0_mispredict_count;

    int total = 0;
    int bad = 0;
    int hitModel = 0;
    int mispModel = 0;

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp;
    } exp_t;

    exp_t sbQ[$];

    always #5 clk = ~clk;

    lc3b_branch_predictor dut (
        .clk(clk), .reset_n(reset_n), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_uncond(upd_uncond), .upd_target(upd_target),
        .upd_mispredict(upd_mispredict), .invalidate(invalidate),
        .hit_count(hit_count), .mispredict_count(mispredict_count)
    );

    lc3b_branch_predictor #(.PERF_WIDTH(4)) dut_p4 (
        .clk(clk), .reset_n(reset_n), .fetch_pc(fetch_pc),
        .pred_taken(p4_pred_taken), .pred_target(p4_pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_uncond(upd_uncond), .upd_target(upd_target),
        .upd_mispredict(upd_mispredict), .invalidate(invalidate),
        .hit_count(p4_hit_count), .mispredict_count(p4_mispredict_count)
    );

    lc3b_branch_predictor #(.MODE(0)) dut_m0 (
        .clk(clk), .reset_n(reset_n), .fetch_pc(fetch_pc),
        .pred_taken(m0_pred_taken), .pred_target(m0_pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_uncond(upd_uncond), .upd_target(upd_target),
        .upd_mispredict(upd_mispredict), .invalidate(invalidate),
        .hit_count(m0_hit_count), .mispredict_count(m0_mispredict_count)
    );

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            0:       observe = {15'd0, pred_taken};
            1:       observe = pred_target;
            2:       observe = hit_count;
            3:       observe = mispredict_count;
            4:       observe = {12'd0, p4_mispredict_count};
            5:       observe = {15'd0, m0_pred_taken};
            6:       observe = m0_pred_target;
            default: observe = m0_hit_count;
        endcase
    endfunction

    task automatic pushExp(input string name, input int sel, input logic [15:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        sbQ.push_back(e);
    endtask

    // Drives one cycle of stimulus at the falling edge and queues what every
    // instance should show before the next rising edge.
    task automatic applyStimulus(input string name, input logic [15:0] fpc,
                                 input logic uv, input logic [15:0] upc,
                                 input logic ut, input logic uu,
                                 input logic [15:0] utgt, input logic um,
                                 input logic inv, input logic expTaken,
                                 input logic [15:0] expTarget, input logic expHit);
        int p4Exp;
        @(negedge clk);
        fetch_pc       = fpc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_uncond     = uu;
        upd_target     = utgt;
        upd_mispredict = um;
        invalidate     = inv;
        p4Exp = (mispModel > 15) ? 15 : mispModel;
        pushExp({name, ".taken"}, 0, {15'd0, expTaken});
        pushExp({name, ".target"}, 1, expTarget);
        pushExp({name, ".hits"}, 2, 16'(hitModel));
        pushExp({name, ".misp"}, 3, 16'(mispModel));
        pushExp({name, ".p4misp"}, 4, 16'(p4Exp));
        pushExp({name, ".m0taken"}, 5, 16'd0);
        pushExp({name, ".m0target"}, 6, fpc + 16'd2);
        pushExp({name, ".m0hits"}, 7, 16'd0);
        if (expHit) hitModel++;
        if (uv && um) mispModel++;
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [15:0] obs;
        #1;
        while (sbQ.size() > 0) begin
            e   = sbQ.pop_front();
            obs = observe(e.sel);
            total++;
            assert (obs === e.exp) else begin
                bad++;
                $error("[TB] FAIL %s observed=%0h expected=%0h", e.name, obs, e.exp);
            end
        end
    endtask

    task automatic runStep(input string name, input logic [15:0] fpc,
                           input logic uv, input logic [15:0] upc,
                           input logic ut, input logic uu,
                           input logic [15:0] utgt, input logic um,
                           input logic inv, input logic expTaken,
                           input logic [15:0] expTarget, input logic expHit);
        applyStimulus(name, fpc, uv, upc, ut, uu, utgt, um, inv, expTaken, expTarget, expHit);
        checkOutput();
    endtask

    initial begin
        reset_n        = 1'b0;
        fetch_pc       = 16'h3000;
        upd_valid      = 1'b0;
        upd_pc         = 16'h0000;
        upd_taken      = 1'b0;
        upd_uncond     = 1'b0;
        upd_target     = 16'h0000;
        upd_mispredict = 1'b0;
        invalidate     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        //       name          fpc      uv  upc      ut  uu  utgt     um  inv  taken tgt     hit
        runStep("reset",       16'h3000, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,   0, 16'h3002, 0);
        runStep("alloc",       16'h3010, 1, 16'h3010, 1, 0, 16'h3040, 1, 0,   0, 16'h3012, 0);
        runStep("alloc_hit",   16'h3010, 1, 16'h3010, 0, 0, 16'h0000, 1, 0,   1, 16'h3040, 1);
        runStep("weak_nt",     16'h3010, 1, 16'h3010, 0, 0, 16'h0000, 0, 0,   0, 16'h3012, 1);
        runStep("strong_nt",   16'h3010, 1, 16'h3010, 1, 0, 16'h3040, 1, 0,   0, 16'h3012, 1);
        runStep("back_weak",   16'h3010, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,   0, 16'h3012, 1);

        runStep("unc_alloc",   16'h3020, 1, 16'h3020, 1, 1, 16'h1234, 1, 0,   0, 16'h3022, 0);
        runStep("unc_nt1",     16'h3020, 1, 16'h3020, 0, 0, 16'h0000, 0, 0,   1, 16'h1234, 1);
        runStep("unc_nt2",     16'h3020, 1, 16'h3020, 0, 0, 16'h0000, 0, 0,   1, 16'h1234, 1);
        runStep("unc_nt3",     16'h3020, 1, 16'h3020, 0, 0, 16'h0000, 0, 0,   1, 16'h1234, 1);
        runStep("unc_hold",    16'h3020, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,   1, 16'h1234, 1);

        runStep("alias_alloc", 16'h3030, 1, 16'h3030, 1, 0, 16'h4000, 0, 0,   0, 16'h3032, 0);
        runStep("alias_old",   16'h3010, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,   0, 16'h3012, 0);
        runStep("alias_new",   16'h3030, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,   1, 16'h4000, 1);

        runStep("same_alloc",  16'h3010, 1, 16'h3010, 1, 0, 16'h3050, 0, 0,   0, 16'h3012, 0);
        runStep("same_cycle",  16'h3010, 1, 16'h3010, 0, 0, 16'h0000, 1, 0,   1, 16'h3050, 1);
        runStep("same_after",  16'h3010, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,   0, 16'h3012, 1);

        runStep("nt_miss",     16'h3060, 1, 16'h3060, 0, 0, 16'h7000, 0, 0,   0, 16'h3062, 0);
        runStep("nt_noalloc",  16'h3060, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,   0, 16'h3062, 0);
        runStep("nt_keep",     16'h3020, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,   1, 16'h1234, 1);
        runStep("wrap",        16'hFFFE, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,   0, 16'h0000, 0);

        runStep("inv",         16'h3020, 1, 16'h3070, 1, 0, 16'h5000, 0, 1,   1, 16'h1234, 1);
        runStep("inv_unc",     16'h3020, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,   0, 16'h3022, 0);
        runStep("inv_drop",    16'h3070, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,   0, 16'h3072, 0);
        runStep("inv_cond",    16'h3010, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,   0, 16'h3012, 0);

        runStep("misp_unqual", 16'h3100, 0, 16'h3100, 0, 0, 16'h0000, 1, 0,   0, 16'h3102, 0);
        for (int i = 0; i < 20; i++) begin
            runStep("misp_sat", 16'h3100, 1, 16'h3100, 0, 0, 16'h0000, 1, 0,  0, 16'h3102, 0);
        end
        runStep("misp_final",  16'h3100, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,   0, 16'h3102, 0);

        // A reset that collides with an update must discard the update.
        @(negedge clk);
        reset_n        = 1'b0;
        fetch_pc       = 16'h3010;
        upd_valid      = 1'b1;
        upd_pc         = 16'h3010;
        upd_taken      = 1'b1;
        upd_uncond     = 1'b0;
        upd_target     = 16'h3040;
        upd_mispredict = 1'b1;
        invalidate     = 1'b0;
        @(negedge clk);
        reset_n   = 1'b1;
        upd_valid = 1'b0;
        hitModel  = 0;
        mispModel = 0;
        runStep("rst_upd",     16'h3010, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,   0, 16'h3012, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lc3b_branch_predictor.md
# lc3b_branch_predictor

Parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters for the pipelined LC-3b core. Fetch queries it every cycle with the current PC and gets a predicted next PC. Branch resolution in the MEM/WB stage trains it, so taken BR/JMP/JSR/TRAP no longer always cost a full flush. It also counts hits and mispredicts for performance runs.

## Interface
Parameters:
- ENTRIES, 16, number of BTB entries; power of two, 2..256.
- PC_WIDTH, 16, address width; bit 0 is always zero (word-aligned fetch).
- PERF_WIDTH, 16, width of each saturating performance counter.
- MODE, 1, 0 = predictor disabled (always predicts not-taken; updates ignored), 1 = bimodal BTB.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- fetch_pc  in  PC_WIDTH  PC being fetched this cycle.
- pred_taken  out  1  combinational prediction for fetch_pc.
- pred_target  out  PC_WIDTH  target when pred_taken = 1, otherwise fetch_pc + 2.
- upd_valid  in  1  resolution event this cycle.
- upd_pc  in  PC_WIDTH  PC of the resolved control instruction.
- upd_taken  in  1  actual direction.
- upd_uncond  in  1  resolved instruction is JMP/JSR/TRAP (always taken).
- upd_target  in  PC_WIDTH  actual target address.
- upd_mispredict  in  1  the fetch stage's prediction for this instruction was wrong; qualified by upd_valid.
- invalidate  in  1  clear every valid bit (for example, on a self-modifying store).
- hit_count  out  PERF_WIDTH  lookups that hit a valid entry.
- mispredict_count  out  PERF_WIDTH  upd_valid && upd_mispredict events.

## Operation
- Address split:
  - index IDX_W = log2(ENTRIES) bits, taken from pc[IDX_W:1].
  - tag is pc[PC_WIDTH-1:IDX_W+1].
- Each entry holds valid, tag, target, uncond and a 2-bit counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup:
  - hit = valid && tag match.
  - pred_taken = hit && (uncond || ctr[1]).
  - pred_target = pred_taken ? target : fetch_pc + 2, computed modulo 2^PC_WIDTH.
- Update when upd_valid, on a hit at upd_pc:
  - uncond: rewrite target, ctr := 11.
  - otherwise: increment the counter if taken, decrement if not, saturating at 11 and 00.
  - if taken, also rewrite the target.
- Update when upd_valid, on a miss:
  - if taken or uncond, allocate: valid := 1, tag and target written, uncond := upd_uncond, ctr := uncond ? 11 : 10.
  - if not taken, leave the table unchanged; not-taken branches are never allocated.
- invalidate clears all valid bits. It takes priority over a simultaneous update: that update is dropped. It does not clear the performance counters.
- Performance counters:
  - hit_count increments on every cycle where hit = 1.
  - both counters saturate at all-ones and never wrap.
- MODE = 0: pred_taken = 0, pred_target = fetch_pc + 2, no table writes. The performance counters still run; hit_count stays 0.

## Timing
- Lookup is combinational from registered state, with zero-cycle latency.
- An update is visible to lookups the cycle after upd_valid.
- Lookup and update in the same cycle, same index: the lookup sees the pre-update contents (no bypass).
- Reset (reset_n = 0 at a rising edge):
  - all valid bits = 0, all counters = 01, uncond = 0.
  - hit_count = mispredict_count = 0.
  - hence pred_taken = 0 and pred_target = fetch_pc + 2 from the first cycle after reset.
  - tag and target arrays need not be reset.
- Reset asserted in the same cycle as upd_valid or invalidate: reset wins.
- No handshake: the caller presents at most one update per cycle, and updates arrive in program order.

## Structure
- Add to lc3b_types:
  - lc3b_bp_ctr_t (2-bit counter type) and the constants BP_STRONG_NT, BP_WEAK_NT, BP_WEAK_T, BP_STRONG_T.
  - lc3b_btb_entry_t, a packed struct parameterised by the fixed 16-bit PC default.
- One sub-module, sat_counter2: combinational next-state for the 2-bit counter, inputs ctr and taken, output next ctr.
- Storage is a flop array; no SRAM macro at this size.
- Performance counters are inline, with no separate module.

## Test plan
- Reset: hold reset_n = 0 for 2 cycles, then fetch_pc = 0x3000. Require pred_taken = 0, pred_target = 0x3002, hit_count = 0.
- Allocate and train (default parameters; 0x3010 → index 8):
  - upd pc 0x3010, taken, target 0x3040 → next cycle, lookup 0x3010 gives pred_taken = 1, pred_target = 0x3040, hit_count increments.
  - then two not-taken updates: counter goes 10 → 01 → 00, pred_taken = 0.
  - then one taken update: counter 01, pred_taken still 0.
- Unconditional: upd pc 0x3020, uncond, target 0x1234, then three not-taken updates on the same PC → pred_taken stays 1, pred_target = 0x1234.
- Alias eviction (ENTRIES = 16):
  - allocate 0x3010, then update 0x3030 taken, target 0x4000 (same index, different tag).
  - lookup 0x3010 → miss, pred_target = 0x3012; lookup 0x3030 → 0x4000.
- Same-cycle update and lookup on 0x3010: the lookup returns the old prediction, and the new one is visible the next cycle. A not-taken miss update → no allocation.
- invalidate asserted with a simultaneous update → all lookups miss, the update is dropped. Mispredict counter saturation with PERF_WIDTH = 4 after 20 events → mispredict_count = 0xF. MODE = 0 → pred_taken = 0 regardless of updates.
